// File: rtl/ensemble_pkg.sv
// Shared constants and types for the three-way classifier vote collector.
package ensemble_pkg;

  localparam int CLASS_WIDTH_DEFAULT = 8;
  localparam int NUM_LANES           = 3;

  // Flag positions in the result beat, counted upward from the top of the label field.
  localparam int UNANIMOUS_OFFSET = 0;
  localparam int TIE_OFFSET       = 1;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } vote_state_e;

endpackage

// File: rtl/ensemble_vote_collector_if.sv
// AXI-Stream style beat bundle used for the three classifier inputs and the voted output.
interface ensemble_vote_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/ensemble_lane_buf.sv
// Single-entry holding buffer for one classifier lane, with a look-through view of the
// beat being captured this cycle so a set can be voted on the edge its last beat lands.
module ensemble_lane_buf
  import ensemble_pkg::*;
#(
  parameter int CLASS_WIDTH = CLASS_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CLASS_WIDTH-1:0] in_label,
  input  logic                   in_keep0,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   clear,
  output logic                   avail,
  output logic [CLASS_WIDTH-1:0] label,
  output logic                   last,
  output logic                   bad_keep
);

  logic                   full_q, full_d;
  logic                   ready_q, ready_d;
  logic                   last_q, last_d;
  logic [CLASS_WIDTH-1:0] label_q, label_d;
  logic                   capture;

  assign capture  = in_valid & ready_q;
  assign in_ready = ready_q;

  assign avail    = full_q | capture;
  assign label    = full_q ? label_q : in_label;
  assign last     = full_q ? last_q : in_last;
  assign bad_keep = capture & ~in_keep0;

  always_comb begin
    full_d  = full_q;
    label_d = label_q;
    last_d  = last_q;
    if (capture) begin
      full_d  = 1'b1;
      label_d = in_label;
      last_d  = in_last;
    end
    if (clear) begin
      full_d = 1'b0;
    end
    // Ready is a flop so it stays low throughout reset and has no input-to-output path.
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      label_q <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      label_q <= label_d;
    end
  end

endmodule

// File: rtl/ensemble_vote_collector.sv
// Collects one result beat from each of three classifiers, majority-votes the class
// label and emits a single flagged result beat downstream.
module ensemble_vote_collector
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = CLASS_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  ensemble_vote_collector_if.slave  s_axis_0,
  ensemble_vote_collector_if.slave  s_axis_1,
  ensemble_vote_collector_if.slave  s_axis_2,
  ensemble_vote_collector_if.master m_axis,
  output logic [15:0]               result_count,
  output logic                      err_sticky
);

  logic [NUM_LANES-1:0]   lane_avail;
  logic [NUM_LANES-1:0]   lane_last;
  logic [NUM_LANES-1:0]   lane_bad_keep;
  logic [CLASS_WIDTH-1:0] lane_label [NUM_LANES];

  logic                   eq01, eq02, eq12;
  logic [CLASS_WIDTH-1:0] vote_label;
  logic                   vote_tie;
  logic                   vote_unanimous;
  logic [DATA_WIDTH-1:0]  vote_data;

  logic                   out_free;
  logic                   vote_fire;
  logic                   handshake;

  vote_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic [15:0]            count_q, count_d;
  logic                   err_q, err_d;

  logic                   unused_inputs;

  // Only the label field and tkeep[0] of each input beat carry meaning here.
  assign unused_inputs = ^{s_axis_0.tdata[DATA_WIDTH-1:CLASS_WIDTH], s_axis_0.tkeep[KEEP_WIDTH-1:1],
                           s_axis_1.tdata[DATA_WIDTH-1:CLASS_WIDTH], s_axis_1.tkeep[KEEP_WIDTH-1:1],
                           s_axis_2.tdata[DATA_WIDTH-1:CLASS_WIDTH], s_axis_2.tkeep[KEEP_WIDTH-1:1]};

  ensemble_lane_buf #(.CLASS_WIDTH(CLASS_WIDTH)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axis_0.tvalid),
    .in_label (s_axis_0.tdata[CLASS_WIDTH-1:0]),
    .in_keep0 (s_axis_0.tkeep[0]),
    .in_last  (s_axis_0.tlast),
    .in_ready (s_axis_0.tready),
    .clear    (vote_fire),
    .avail    (lane_avail[0]),
    .label    (lane_label[0]),
    .last     (lane_last[0]),
    .bad_keep (lane_bad_keep[0])
  );

  ensemble_lane_buf #(.CLASS_WIDTH(CLASS_WIDTH)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axis_1.tvalid),
    .in_label (s_axis_1.tdata[CLASS_WIDTH-1:0]),
    .in_keep0 (s_axis_1.tkeep[0]),
    .in_last  (s_axis_1.tlast),
    .in_ready (s_axis_1.tready),
    .clear    (vote_fire),
    .avail    (lane_avail[1]),
    .label    (lane_label[1]),
    .last     (lane_last[1]),
    .bad_keep (lane_bad_keep[1])
  );

  ensemble_lane_buf #(.CLASS_WIDTH(CLASS_WIDTH)) u_lane2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axis_2.tvalid),
    .in_label (s_axis_2.tdata[CLASS_WIDTH-1:0]),
    .in_keep0 (s_axis_2.tkeep[0]),
    .in_last  (s_axis_2.tlast),
    .in_ready (s_axis_2.tready),
    .clear    (vote_fire),
    .avail    (lane_avail[2]),
    .label    (lane_label[2]),
    .last     (lane_last[2]),
    .bad_keep (lane_bad_keep[2])
  );

  // Majority of three; with no pair in agreement, lane 0 wins and the tie flag is raised.
  always_comb begin
    eq01           = (lane_label[0] == lane_label[1]);
    eq02           = (lane_label[0] == lane_label[2]);
    eq12           = (lane_label[1] == lane_label[2]);
    vote_label     = lane_label[0];
    vote_tie       = 1'b0;
    vote_unanimous = eq01 & eq02;
    if (!eq01 && !eq02) begin
      if (eq12) begin
        vote_label = lane_label[1];
      end else begin
        vote_tie = 1'b1;
      end
    end
    vote_data                                 = '0;
    vote_data[CLASS_WIDTH-1:0]                = vote_label;
    vote_data[CLASS_WIDTH + UNANIMOUS_OFFSET] = vote_unanimous;
    vote_data[CLASS_WIDTH + TIE_OFFSET]       = vote_tie;
  end

  assign handshake = (state_q == EMIT) & m_axis.tready;
  assign out_free  = (state_q == COLLECT) | m_axis.tready;
  assign vote_fire = (&lane_avail) & out_free;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = err_q;
    if (handshake) begin
      count_d = count_q + 16'd1;
    end
    if (|lane_bad_keep) begin
      err_d = 1'b1;
    end
    // A reload on the draining edge keeps the output busy with no idle cycle between results.
    if (vote_fire) begin
      state_d = EMIT;
      data_d  = vote_data;
      last_d  = lane_last[0];
      if ((|lane_last) && !(&lane_last)) begin
        err_d = 1'b1;
      end
    end else if (handshake) begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      data_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign m_axis.tvalid = (state_q == EMIT);
  assign m_axis.tdata  = data_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tkeep  = '1;
  assign result_count  = count_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_ensemble_vote_collector.sv
// Scoreboard bench for ensemble_vote_collector: directed scenarios plus randomized sets,
// checked against a per-lane queue model of the majority vote.
module tb_ensemble_vote_collector;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        m_ready;
  logic [15:0] result_count;
  logic        err_sticky;

  logic [2:0]  valid_drv;
  logic [2:0]  last_drv;
  logic [31:0] data_drv [3];
  logic [3:0]  keep_drv [3];
  logic [2:0]  lane_ready;

  beat_t drv_q [3][$];
  beat_t mlane [3][$];
  exp_t  sb [$];

  int    tests;
  int    fails;
  int    sets_formed;
  logic  exp_err;
  logic  gap_en;
  logic  rand_ready;

  ensemble_vote_collector_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s_if0 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s_if1 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s_if2 ();
  ensemble_vote_collector_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) m_if ();

  assign s_if0.tdata  = data_drv[0];
  assign s_if0.tkeep  = keep_drv[0];
  assign s_if0.tvalid = valid_drv[0];
  assign s_if0.tlast  = last_drv[0];
  assign s_if1.tdata  = data_drv[1];
  assign s_if1.tkeep  = keep_drv[1];
  assign s_if1.tvalid = valid_drv[1];
  assign s_if1.tlast  = last_drv[1];
  assign s_if2.tdata  = data_drv[2];
  assign s_if2.tkeep  = keep_drv[2];
  assign s_if2.tvalid = valid_drv[2];
  assign s_if2.tlast  = last_drv[2];
  assign lane_ready   = {s_if2.tready, s_if1.tready, s_if0.tready};
  assign m_if.tready  = m_ready;

  ensemble_vote_collector #(
    .DATA_WIDTH  (32),
    .KEEP_WIDTH  (4),
    .CLASS_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_0     (s_if0),
    .s_axis_1     (s_if1),
    .s_axis_2     (s_if2),
    .m_axis       (m_if),
    .result_count (result_count),
    .err_sticky   (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference vote: the first label held by at least two lanes wins; otherwise lane 0 with tie.
  function automatic logic [31:0] refVote(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    logic [7:0]  lab [3];
    logic [31:0] r;
    int          votes;
    logic [7:0]  winner;
    logic        tie;
    logic        unanimous;
    lab[0] = l0;
    lab[1] = l1;
    lab[2] = l2;
    winner = l0;
    tie    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      votes = 0;
      for (int j = 0; j < 3; j++) if (lab[j] == lab[c]) votes++;
      if (votes >= 2 && tie) begin
        winner = lab[c];
        tie    = 1'b0;
      end
    end
    votes = 0;
    for (int j = 0; j < 3; j++) if (lab[j] == l0) votes++;
    unanimous = (votes == 3);
    r         = '0;
    r[7:0]    = winner;
    r[8]      = unanimous;
    r[9]      = tie;
    return r;
  endfunction

  // Sets are formed strictly in arrival order per lane, so the model pairs the n-th beats.
  task automatic formSets();
    beat_t a, b, c;
    exp_t  e;
    while (mlane[0].size() > 0 && mlane[1].size() > 0 && mlane[2].size() > 0) begin
      a      = mlane[0].pop_front();
      b      = mlane[1].pop_front();
      c      = mlane[2].pop_front();
      e.data = refVote(a.data[7:0], b.data[7:0], c.data[7:0]);
      e.last = a.last;
      if (!(a.last == b.last && b.last == c.last)) exp_err = 1'b1;
      sb.push_back(e);
      sets_formed++;
    end
  endtask

  task automatic pushBeat(input int k, input logic [7:0] label, input logic last, input logic keep0);
    beat_t b;
    b.data      = $urandom;
    b.data[7:0] = label;
    b.keep      = 4'($urandom_range(0, 15));
    b.keep[0]   = keep0;
    b.last      = last;
    drv_q[k].push_back(b);
    mlane[k].push_back(b);
    if (!keep0) exp_err = 1'b1;
    formSets();
  endtask

  task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                               input logic [2:0] lasts, input logic [2:0] keep0s);
    pushBeat(0, l0, lasts[0], keep0s[0]);
    pushBeat(1, l1, lasts[1], keep0s[1]);
    pushBeat(2, l2, lasts[2], keep0s[2]);
  endtask

  // Lane drivers: hold each beat until the handshake sampled before the edge completes it.
  initial begin
    logic [2:0] acc;
    beat_t      b;
    valid_drv = '0;
    last_drv  = '0;
    for (int k = 0; k < 3; k++) begin
      data_drv[k] = '0;
      keep_drv[k] = '1;
    end
    forever begin
      @(negedge clk);
      acc = valid_drv & lane_ready & {3{~rst}};
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rst || acc[k]) valid_drv[k] = 1'b0;
        if (!rst && !valid_drv[k] && drv_q[k].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
          b            = drv_q[k].pop_front();
          data_drv[k]  = b.data;
          keep_drv[k]  = b.keep;
          last_drv[k]  = b.last;
          valid_drv[k] = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold-while-stalled.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", 32'(m_if.tvalid), 32'd1);
          checkOutput("hold_data", m_if.tdata, prev_data);
          checkOutput("hold_last", 32'(m_if.tlast), 32'(prev_last));
        end
        if (m_if.tvalid && m_ready) begin
          checkOutput("result_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("result_data", m_if.tdata, e.data);
            checkOutput("result_last", 32'(m_if.tlast), 32'(e.last));
            checkOutput("result_keep", 32'(m_if.tkeep), 32'hF);
          end
        end
        prev_stall = m_if.tvalid && !m_ready;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("rst_tdata", m_if.tdata, 32'd0);
    checkOutput("rst_tlast", 32'(m_if.tlast), 32'd0);
    checkOutput("rst_tkeep", 32'(m_if.tkeep), 32'hF);
    checkOutput("rst_count", 32'(result_count), 32'd0);
    checkOutput("rst_err", 32'(err_sticky), 32'd0);
    checkOutput("rst_tready", 32'(lane_ready), 32'd0);
  endtask

  // Asserts reset mid-stream and discards everything the model was still expecting.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_q[k].delete();
      mlane[k].delete();
    end
    sb.delete();
    sets_formed = 0;
    exp_err     = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_reset", 32'(lane_ready), 32'h7);
  endtask

  task automatic setReady(input logic value);
    @(posedge clk);
    #2;
    m_ready = value;
  endtask

  task automatic waitDrain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && drv_q[0].size() == 0 && drv_q[1].size() == 0 && drv_q[2].size() == 0 &&
          valid_drv == 3'b000 && !m_if.tvalid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_count"}, 32'(result_count), 32'(sets_formed[15:0]));
    checkOutput({name, "_err"}, 32'(err_sticky), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] l0, l1, l2;
    logic       lst;
    tests       = 0;
    fails       = 0;
    sets_formed = 0;
    exp_err     = 1'b0;
    gap_en      = 1'b0;
    rand_ready  = 1'b0;
    m_ready     = 1'b0;
    rst         = 1'b1;

    doReset();
    setReady(1'b1);

    // Unanimous set arriving together: result visible the cycle after capture.
    @(negedge clk);
    checkOutput("count_before_first", 32'(result_count), 32'd0);
    applyStimulus(8'd3, 8'd3, 8'd3, 3'b000, 3'b111);
    @(negedge clk);
    checkOutput("latency_not_early", 32'(m_if.tvalid), 32'd0);
    @(negedge clk);
    checkOutput("latency_one_cycle", 32'(m_if.tvalid), 32'd1);
    waitDrain("unanimous");
    checkQuiet("unanimous");

    // Staggered arrivals: lane 1 stays blocked until the set completes.
    pushBeat(0, 8'd5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    pushBeat(1, 8'd2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("lane1_blocked", 32'(lane_ready[1]), 32'd0);
    repeat (2) @(negedge clk);
    pushBeat(2, 8'd5, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stagger_not_early", 32'(m_if.tvalid), 32'd0);
    checkOutput("lane1_still_blocked", 32'(lane_ready[1]), 32'd0);
    @(negedge clk);
    checkOutput("stagger_valid", 32'(m_if.tvalid), 32'd1);
    checkOutput("lane1_released", 32'(lane_ready[1]), 32'd1);
    waitDrain("stagger");
    checkQuiet("stagger");

    // All three labels differ.
    @(negedge clk);
    applyStimulus(8'd1, 8'd2, 8'd7, 3'b111, 3'b111);
    waitDrain("tie");
    checkQuiet("tie");

    // Downstream stall with the next set already collected, then back-to-back drain.
    setReady(1'b0);
    @(negedge clk);
    applyStimulus(8'd7, 8'd7, 8'd1, 3'b000, 3'b111);
    applyStimulus(8'd2, 8'd8, 8'd8, 3'b111, 3'b111);
    repeat (8) @(negedge clk);
    checkOutput("stall_valid", 32'(m_if.tvalid), 32'd1);
    checkOutput("stall_lanes_full", 32'(lane_ready), 32'd0);
    setReady(1'b1);
    @(negedge clk);
    checkOutput("drain_first", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    checkOutput("no_bubble", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    checkOutput("drained", 32'(m_if.tvalid), 32'd0);
    checkQuiet("stall");

    // Randomized well-formed sets with gaps on every lane and random backpressure.
    gap_en     = 1'b1;
    rand_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        l0 = 8'($urandom_range(0, 255));
        l1 = 8'($urandom_range(0, 255));
        l2 = 8'($urandom_range(0, 255));
      end else begin
        l0 = 8'($urandom_range(0, 3));
        l1 = 8'($urandom_range(0, 3));
        l2 = 8'($urandom_range(0, 3));
      end
      lst = 1'($urandom_range(0, 1));
      applyStimulus(l0, l1, l2, {3{lst}}, 3'b111);
    end
    waitDrain("random");
    rand_ready = 1'b0;
    gap_en     = 1'b0;
    setReady(1'b1);
    checkQuiet("random");

    // Mismatched tlast: still voted, lane 0 tlast forwarded, error latched.
    @(negedge clk);
    applyStimulus(8'd6, 8'd6, 8'd6, 3'b101, 3'b111);
    waitDrain("tlast_err");
    checkQuiet("tlast_err");
    repeat (5) @(negedge clk);
    checkOutput("err_held", 32'(err_sticky), 32'd1);

    // Lane 2 beat with tkeep[0] clear.
    doReset();
    @(negedge clk);
    applyStimulus(8'd9, 8'd4, 8'd4, 3'b111, 3'b011);
    waitDrain("keep_err");
    checkQuiet("keep_err");

    // Reset with a pending result and two lanes full, then a fresh set.
    doReset();
    setReady(1'b0);
    @(negedge clk);
    applyStimulus(8'd1, 8'd1, 8'd1, 3'b000, 3'b111);
    repeat (4) @(negedge clk);
    pushBeat(0, 8'd4, 1'b0, 1'b1);
    pushBeat(1, 8'd4, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pending_before_reset", 32'(m_if.tvalid), 32'd1);
    checkOutput("two_lanes_full", 32'(lane_ready[1:0]), 32'd0);
    doReset();
    setReady(1'b1);
    @(negedge clk);
    applyStimulus(8'd4, 8'd4, 8'd9, 3'b000, 3'b111);
    waitDrain("after_reset");
    checkQuiet("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
